// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and default widths for the front-panel command path
package calc_pkg;

    localparam int CALC_DATA_W      = 8;
    localparam int CALC_ACC_W       = 12;
    localparam int CALC_CNT_W       = 4;
    localparam int CALC_MAX_ENTRIES = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHOW  = 2'd2,
        ST_ERROR = 2'd3
    } calcState_e;

    // One-hot command bundle, same field order as the button controller drives it
    typedef struct packed {
        logic enter;
        logic number;
        logic total;
        logic clear;
    } calcCmd_t;

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - single-bit rising-edge detector with async active-low reset
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic history;
    logic primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history <= 1'b0;
            primed  <= 1'b0;
        end else begin
            history <= level;
            primed  <= 1'b1;
        end
    end

    // A level already high when reset releases is absorbed into history, not reported
    assign rise = level & ~history & primed;

endmodule

// File: rtl/calc_command_executor.sv
// rtl/calc_command_executor.sv - accumulator state machine behind the front-panel commands
module calc_command_executor
    import calc_pkg::*;
#(
    parameter int DATA_W      = CALC_DATA_W,
    parameter int ACC_W       = CALC_ACC_W,
    parameter int MAX_ENTRIES = CALC_MAX_ENTRIES,
    parameter int CNT_W       = CALC_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enter,
    input  logic              number,
    input  logic              total,
    input  logic              clear,
    input  logic              err,
    input  logic [DATA_W-1:0] num_in,
    output logic [ACC_W-1:0]  display,
    output logic [CNT_W-1:0]  count,
    output logic              total_valid,
    output logic              overflow,
    output logic              err_flag,
    output logic [1:0]        state_o
);

    calcState_e        state;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] pending;
    logic              enterRise;
    logic              numberRise;
    logic              totalRise;
    logic              clearRise;
    calcCmd_t          cmdRise;
    logic              multiCmd;
    logic [ACC_W:0]    sum;

    edge_detect uEnterEdge  (.clk(clk), .rst_n(rst_n), .level(enter),  .rise(enterRise));
    edge_detect uNumberEdge (.clk(clk), .rst_n(rst_n), .level(number), .rise(numberRise));
    edge_detect uTotalEdge  (.clk(clk), .rst_n(rst_n), .level(total),  .rise(totalRise));
    edge_detect uClearEdge  (.clk(clk), .rst_n(rst_n), .level(clear),  .rise(clearRise));

    assign cmdRise  = {enterRise, numberRise, totalRise, clearRise};
    assign multiCmd = (cmdRise.enter & cmdRise.number) | (cmdRise.enter & cmdRise.total)
                    | (cmdRise.number & cmdRise.total);
    assign sum      = {1'b0, acc} + {{(ACC_W - DATA_W + 1){1'b0}}, pending};
    assign state_o  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            acc         <= '0;
            pending     <= '0;
            display     <= '0;
            count       <= '0;
            total_valid <= 1'b0;
            overflow    <= 1'b0;
            err_flag    <= 1'b0;
        end else if (err || multiCmd) begin
            state       <= ST_ERROR;
            err_flag    <= 1'b1;
            total_valid <= 1'b0;
        end else if (cmdRise.clear) begin
            state       <= ST_IDLE;
            acc         <= '0;
            pending     <= '0;
            display     <= '0;
            count       <= '0;
            total_valid <= 1'b0;
            overflow    <= 1'b0;
            err_flag    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_SHOW: begin
                    if (cmdRise.number) begin
                        state       <= ST_ARMED;
                        pending     <= num_in;
                        display     <= {{(ACC_W - DATA_W){1'b0}}, num_in};
                        total_valid <= 1'b0;
                    end else if (cmdRise.total && state == ST_IDLE) begin
                        state       <= ST_SHOW;
                        display     <= acc;
                        total_valid <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (cmdRise.number) begin
                        pending <= num_in;
                        display <= {{(ACC_W - DATA_W){1'b0}}, num_in};
                    end else if (cmdRise.enter) begin
                        if (count == CNT_W'(MAX_ENTRIES)) begin
                            state    <= ST_ERROR;
                            err_flag <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            count <= count + 1'b1;
                            // Carry out of the ACC_W-bit add pins the result at full scale
                            if (sum[ACC_W]) begin
                                acc      <= '1;
                                display  <= '1;
                                overflow <= 1'b1;
                            end else begin
                                acc     <= sum[ACC_W-1:0];
                                display <= sum[ACC_W-1:0];
                            end
                        end
                    end else if (cmdRise.total) begin
                        state       <= ST_SHOW;
                        display     <= acc;
                        total_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_command_executor.sv
// tb/tb_calc_command_executor.sv - self-checking bench for calc_command_executor
module tb_calc_command_executor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enter, number, total, clear, err;
    logic [7:0]  num_in;

    logic [11:0] dispA, dispB;
    logic [3:0]  cntA;
    logic [4:0]  cntB;
    logic        tvA, tvB, ovA, ovB, efA, efB;
    logic [1:0]  stA, stB;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    calc_command_executor dutA (
        .clk(clk), .rst_n(rst_n), .enter(enter), .number(number), .total(total),
        .clear(clear), .err(err), .num_in(num_in), .display(dispA), .count(cntA),
        .total_valid(tvA), .overflow(ovA), .err_flag(efA), .state_o(stA)
    );

    calc_command_executor #(.DATA_W(8), .ACC_W(12), .MAX_ENTRIES(31), .CNT_W(5)) dutB (
        .clk(clk), .rst_n(rst_n), .enter(enter), .number(number), .total(total),
        .clear(clear), .err(err), .num_in(num_in), .display(dispB), .count(cntB),
        .total_valid(tvB), .overflow(ovB), .err_flag(efB), .state_o(stB)
    );

    // Reference model: index 0 mirrors dutA (15 entries), index 1 dutB (31 entries)
    int mSt[2], mAcc[2], mPend[2], mDisp[2], mCnt[2], mTv[2], mOv[2], mEf[2];
    int maxE[2] = '{15, 31};
    int pE, pN, pT, pC, primed;
    localparam int ACC_MAX = 4095;

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            mSt[i] = 0; mAcc[i] = 0; mPend[i] = 0; mDisp[i] = 0;
            mCnt[i] = 0; mTv[i] = 0; mOv[i] = 0; mEf[i] = 0;
        end
        pE = 0; pN = 0; pT = 0; pC = 0; primed = 0;
    endtask

    task automatic modelStep();
        int eE, eN, eT, eC, s;
        eE = (enter  && !pE && primed) ? 1 : 0;
        eN = (number && !pN && primed) ? 1 : 0;
        eT = (total  && !pT && primed) ? 1 : 0;
        eC = (clear  && !pC && primed) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            if (err || (eE + eN + eT) > 1) begin
                mSt[i] = 3; mEf[i] = 1; mTv[i] = 0;
            end else if (eC != 0) begin
                mSt[i] = 0; mAcc[i] = 0; mPend[i] = 0; mDisp[i] = 0;
                mCnt[i] = 0; mTv[i] = 0; mOv[i] = 0; mEf[i] = 0;
            end else if (mSt[i] != 3) begin
                if (eN != 0) begin
                    mPend[i] = num_in; mDisp[i] = num_in; mTv[i] = 0; mSt[i] = 1;
                end else if (eE != 0 && mSt[i] == 1) begin
                    if (mCnt[i] == maxE[i]) begin
                        mSt[i] = 3; mEf[i] = 1; mTv[i] = 0;
                    end else begin
                        s = mAcc[i] + mPend[i];
                        if (s > ACC_MAX) begin
                            s = ACC_MAX; mOv[i] = 1;
                        end
                        mAcc[i] = s; mDisp[i] = s; mCnt[i]++; mSt[i] = 0;
                    end
                end else if (eT != 0 && mSt[i] != 2) begin
                    mDisp[i] = mAcc[i]; mTv[i] = 1; mSt[i] = 2;
                end
            end
        end
        pE = enter; pN = number; pT = total; pC = clear; primed = 1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        chk({tag, " dispA"}, int'(dispA), mDisp[0]);
        chk({tag, " cntA"},  int'(cntA),  mCnt[0]);
        chk({tag, " tvA"},   int'(tvA),   mTv[0]);
        chk({tag, " ovA"},   int'(ovA),   mOv[0]);
        chk({tag, " efA"},   int'(efA),   mEf[0]);
        chk({tag, " stA"},   int'(stA),   mSt[0]);
        chk({tag, " dispB"}, int'(dispB), mDisp[1]);
        chk({tag, " cntB"},  int'(cntB),  mCnt[1]);
        chk({tag, " tvB"},   int'(tvB),   mTv[1]);
        chk({tag, " ovB"},   int'(ovB),   mOv[1]);
        chk({tag, " efB"},   int'(efB),   mEf[1]);
        chk({tag, " stB"},   int'(stB),   mSt[1]);
    endtask

    // Inputs change on the falling edge; the model steps on the rising edge it sees
    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic setCmd(input int c, input int v);
        case (c)
            0: enter  = v[0];
            1: number = v[0];
            2: total  = v[0];
            3: clear  = v[0];
            default: err = v[0];
        endcase
    endtask

    task automatic press(input int c, input int n);
        num_in = n[7:0];
        setCmd(c, 1);
        tick();
        setCmd(c, 0);
        tick();
    endtask

    typedef struct {
        int cmd;
        int num;
        int expDisp;
        int expCnt;
        int expTv;
        int expSt;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{1,  25,  25, 0, 0, 1};
        vecs[1] = '{0,   0,  25, 1, 0, 0};
        vecs[2] = '{1, 100, 100, 1, 0, 1};
        vecs[3] = '{0,   0, 125, 2, 0, 0};
        vecs[4] = '{2,   0, 125, 2, 1, 2};

        rst_n = 1'b0; enter = 0; number = 0; total = 0; clear = 0; err = 0; num_in = 0;
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        checkAll("reset");

        // Basic accumulate and show
        for (int i = 0; i < 5; i++) begin
            press(vecs[i].cmd, vecs[i].num);
            chk($sformatf("vec%0d display", i), int'(dispA), vecs[i].expDisp);
            chk($sformatf("vec%0d count", i),   int'(cntA),  vecs[i].expCnt);
            chk($sformatf("vec%0d tv", i),      int'(tvA),   vecs[i].expTv);
            chk($sformatf("vec%0d state", i),   int'(stA),   vecs[i].expSt);
            chk($sformatf("vec%0d ovf", i),     int'(ovA),   0);
        end
        checkAll("table");

        // Held enter gives exactly one addition
        press(3, 0);
        num_in = 8'd7; number = 1; tick(); number = 0; tick();
        enter = 1;
        repeat (10) tick();
        enter = 0; tick();
        chk("hold display", int'(dispA), 7);
        chk("hold count", int'(cntA), 1);
        checkAll("hold");

        // Entry limit on dutA, saturation on dutB
        press(3, 0);
        for (int i = 0; i < 15; i++) begin
            press(1, 255);
            press(0, 0);
        end
        chk("limit display", int'(dispA), 3825);
        chk("limit count", int'(cntA), 15);
        press(1, 255);
        press(0, 0);
        chk("limit err_flag", int'(efA), 1);
        chk("limit state", int'(stA), 3);
        chk("limit display held", int'(dispA), 255);
        chk("limit count held", int'(cntA), 15);
        press(1, 255);
        press(0, 0);
        chk("sat display", int'(dispB), 4095);
        chk("sat overflow", int'(ovB), 1);
        chk("sat count", int'(cntB), 17);
        checkAll("limit");
        press(3, 0);
        chk("sat clear display", int'(dispB), 0);
        chk("sat clear overflow", int'(ovB), 0);
        chk("sat clear count", int'(cntB), 0);
        checkAll("satclr");

        // Error while armed is sticky until clear without err
        press(1, 5);
        err = 1; tick(); err = 0; tick();
        chk("err flag", int'(efA), 1);
        chk("err state", int'(stA), 3);
        press(1, 9); press(0, 0); press(2, 0);
        chk("err display held", int'(dispA), 5);
        chk("err state held", int'(stA), 3);
        err = 1; clear = 1; tick(); err = 0; clear = 0; tick();
        chk("err clear blocked", int'(stA), 3);
        press(3, 0);
        chk("err cleared state", int'(stA), 0);
        chk("err cleared flag", int'(efA), 0);
        checkAll("err");

        // Simultaneous number and enter edges count as an error
        num_in = 8'd3; number = 1; enter = 1; tick(); number = 0; enter = 0; tick();
        chk("multi state", int'(stA), 3);
        press(3, 0);

        // Asynchronous reset mid-ARMED
        press(1, 9);
        chk("armed display", int'(dispA), 9);
        #3 rst_n = 1'b0;
        #1;
        chk("async display", int'(dispA), 0);
        chk("async state", int'(stA), 0);
        chk("async count", int'(cntA), 0);
        modelReset();
        number = 1; num_in = 8'd33;
        @(negedge clk);
        rst_n = 1'b1;
        tick(); tick();
        chk("held-at-release display", int'(dispA), 0);
        chk("held-at-release state", int'(stA), 0);
        number = 0; tick();
        press(0, 0);
        chk("post-reset count", int'(cntA), 0);
        chk("post-reset display", int'(dispA), 0);
        checkAll("postrst");

        // Randomized traffic against the model
        for (int k = 0; k < 600; k++) begin
            int a;
            a = $urandom_range(0, 19);
            if (a < 18) begin
                enter = 0; number = 0; total = 0; clear = 0; err = 0;
            end
            num_in = 8'($urandom_range(0, 255));
            if (a < 6)       number = 1;
            else if (a < 12) enter = 1;
            else if (a < 14) total = 1;
            else if (a == 14) clear = 1;
            else if (a == 15) err = 1;
            else if (a == 17) begin number = 1; total = 1; end
            tick();
            checkAll($sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
